// File: rtl/pipeline_skid_register.sv
// Two-entry elastic buffer (main + skid) between pipeline stages.
// in_ready comes only from registered state and rst, so downstream
// backpressure never forms a combinational path back to the producer.
module pipeline_skid_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign skid_valid = (state_q == ST_FULL);

  assign in_ready  = rst & ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and data-load decisions; registers load only on a fire term.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Buffered words and any same-cycle input are dropped; data may stay stale.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end else if (in_fire) begin
            // Consumer stalled: park the new word in the skid register.
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= {WIDTH{1'b0}};
      skid_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Self-checking bench for pipeline_skid_register: directed scenarios plus
// random traffic, all compared against a queue-based FIFO reference model.
module tb_pipeline_skid_register;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int n_checks;
  int n_fail;

  // Reference model: words currently held, in arrival order.
  logic [WIDTH-1:0] model_q[$];
  bit               data_zero_m;

  pipeline_skid_register #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy);
    bit rdy_m;
    bit ifire;
    bit ofire;
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    rdy_m = r && (model_q.size() < 2);
    check_value("in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
    check_value("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
    check_value("occupancy", {30'd0, occupancy}, model_q.size());
    if (model_q.size() != 0) begin
      check_value("out_data", out_data, model_q[0]);
    end else if (data_zero_m) begin
      check_value("out_data_zero", out_data, 32'd0);
    end
    ifire = iv && rdy_m;
    ofire = (model_q.size() != 0) && ordy;
    @(posedge clk);
    if (!r) begin
      model_q.delete();
      data_zero_m = 1'b1;
    end else if (f) begin
      model_q.delete();
    end else begin
      if (ofire) void'(model_q.pop_front());
      if (ifire) begin
        model_q.push_back(d);
        data_zero_m = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    data_zero_m = 1'b1;
    rst         = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'd0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);

    // Reset: a word offered during reset must not be captured.
    step(1'b0, 1'b0, 1'b1, 32'h96, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h96, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h96, 1'b1);
    check_value("post_reset_out_data", out_data, 32'd0);

    // Streaming at full throughput.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, i, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Backpressure fill, third word held until space opens.
    step(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
    check_value("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'hC, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Stall stability with toggling input data.
    step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 1'b0);
      check_value("stall_data", out_data, 32'h55);
    end
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Flush from FULL with a colliding input word.
    step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h33, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    check_value("flush_occ", {30'd0, occupancy}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset in the middle of operation.
    step(1'b1, 1'b0, 1'b1, 32'h77, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h99, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h88, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check_value("mid_reset_first", out_data, 32'h88);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 60) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           $urandom,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_register.md
Name: pipeline_skid_register

Overview:
- Two-entry elastic buffer between pipeline stages, with valid/ready handshakes on both sides.
- Decouples upstream enable/advance from downstream backpressure. The consumer side can stall without dropping data or creating a combinational ready path.
- Sits wherever a stage boundary must absorb a one-cycle stall at full throughput.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  input  1  discard all buffered words at the next edge.
- in_valid  input  1  upstream word present on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  word present on out_data.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  oldest buffered word.
- occupancy  output  2  number of buffered words (0..2).

Behaviour:
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A word transfers on the rising edge of any cycle where its fire term is 1.
- Storage: main register (drives out_data) and skid register. Both are WIDTH bits, each with its own valid bit.
- States:
  - EMPTY: occupancy=0.
  - BUSY: main valid, occupancy=1.
  - FULL: main and skid valid, occupancy=2.
- Reset (rst==0 at a clock edge):
  - Next state EMPTY.
  - out_valid=0, out_data=0, skid cleared, occupancy=0.
  - in_ready is forced to 0 combinationally while rst==0.
  - After rst returns to 1, in_ready=1 in the first cycle.
- Output signals:
  - in_ready = rst & ~skid_valid. It is a register-driven term with no path from out_ready.
  - out_valid = main_valid.
  - occupancy = main_valid + skid_valid.
- Transitions (flush==0):
  - EMPTY, in_fire: main<=in_data, go to BUSY. out_fire is impossible in EMPTY.
  - BUSY, in_fire & out_fire: main<=in_data, stay BUSY.
  - BUSY, in_fire & ~out_ready: skid<=in_data, go to FULL. main is unchanged.
  - BUSY, ~in_fire & out_fire: go to EMPTY.
  - BUSY, neither fire: hold.
  - FULL (in_ready=0), out_fire: main<=skid, go to BUSY.
  - FULL, no out_fire: hold.
- Latency and throughput:
  - A word accepted at edge N appears on out_data from cycle N+1.
  - Sustained throughput is 1 word/cycle when out_ready stays 1.
- Ordering: strict FIFO. No word is duplicated or lost except by flush or reset.
- Stability:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold constant.
  - This holds regardless of in_valid.
- Flush (flush==1 at an edge):
  - Next state EMPTY. main and skid valid bits clear.
  - A word presented with in_fire in the same cycle is discarded.
  - A word presented with out_fire in the same cycle counts as consumed.
  - out_data may retain its stale value; out_valid=0.
  - Flush has priority over all transitions. Reset has priority over flush.
- Reset mid-operation: buffered words are discarded at that edge; same result as reset from idle.
- X-safety: in_data is not sampled when in_fire=0. Registers load only on the conditions listed above.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 two edges with in_valid=1, in_data=0x96.
  - Required: in_ready=0, out_valid=0, out_data=0, occupancy=0.
  - Release rst: in_ready=1 in the next cycle, and 0x96 is not captured while rst==0.
- Streaming:
  - Stimulus: out_ready=1, send 0x1,0x2,0x3,0x4 on consecutive cycles.
  - Required: out_data shows 0x1..0x4 on consecutive cycles, each one cycle after acceptance.
  - Required: occupancy=1 throughout, in_ready never drops.
- Backpressure fill:
  - Stimulus: out_ready=0, send 0xA then 0xB.
  - Required: occupancy 1 then 2, and in_ready=0 after 0xB. A third word 0xC held on in_data is not accepted.
  - Stimulus: raise out_ready.
  - Required: outputs 0xA, then 0xB, then 0xC in order; in_ready returns 1 one cycle after the first out_fire.
- Stall stability:
  - Stimulus: out_valid=1 with 0x55 and out_ready=0 for 5 cycles while in_data toggles.
  - Required: out_data stays 0x55 for all 5 cycles.
- Flush:
  - Stimulus: in FULL state (0x11, 0x22), assert flush with in_valid=1, in_data=0x33.
  - Required: next cycle occupancy=0, out_valid=0, in_ready=1.
  - Required: 0x11, 0x22 and 0x33 never appear with out_valid=1.
- Reset mid-operation:
  - Stimulus: in BUSY with 0x77, drive rst=0 together with flush=0 and in_fire conditions.
  - Required: EMPTY after that edge; the next accepted word 0x88 is the first output.
